readout_rx_iq_window_integrator: RTL and testbench

- Upstream stage of the readout RX state-decision unit.
- Takes demodulated per-sample I/Q, boxcar-integrates it over programmable windows of WINDOW_LEN valid samples, and emits one scaled, saturated I/Q point per window.
- Frames each measurement's window stream with start_count_out and finish_count_out so the classifier/accumulator chain can bin it directly.

---
 rtl/readout_rx_pkg.sv | 12 +
 rtl/readout_rx_iq_sat_shift.sv | 13 +
 rtl/readout_rx_iq_window_integrator.sv | 111 +++++++++++
 tb/tb_readout_rx_iq_window_integrator.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_rx_pkg.sv
// readout_rx_pkg: state encoding and shift/saturate helper shared by the readout RX blocks.
package readout_rx_pkg;
  typedef enum logic {IDLE, ACCUM} rx_state_e;
  // Arithmetic shift (floor) followed by a clamp to a signed dw-bit range.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] x, input int shift, input int dw);
    logic signed [63:0] s, hi, lo;
    s = x >>> shift;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    return s > hi ? hi : (s < lo ? lo : s);
  endfunction
endpackage

// File: rtl/readout_rx_iq_sat_shift.sv
// readout_rx_iq_sat_shift: combinational arithmetic shift plus saturation of one accumulator lane.
module readout_rx_iq_sat_shift
  import readout_rx_pkg::*;
#(
  parameter int IN_WIDTH = 24,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT = 8
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout
);
  assign dout = OUT_WIDTH'(sat_shift(64'(din), SHIFT, OUT_WIDTH));
endmodule

// File: rtl/readout_rx_iq_window_integrator.sv
// readout_rx_iq_window_integrator: boxcar-integrates I/Q over programmable windows and frames each measurement.
module readout_rx_iq_window_integrator
  import readout_rx_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int WINDOW_COUNTER_WIDTH = 8,
  parameter int NUM_WINDOW_WIDTH = 8,
  parameter int ACC_WIDTH = SAMPLE_WIDTH + WINDOW_COUNTER_WIDTH,
  parameter int OUT_SHIFT = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               window_len_wr_en,
  input  logic [WINDOW_COUNTER_WIDTH-1:0]    window_len_wr_data,
  input  logic                               num_window_wr_en,
  input  logic [NUM_WINDOW_WIDTH-1:0]        num_window_wr_data,
  input  logic                               meas_start,
  input  logic                               meas_abort,
  input  logic                               valid_in,
  input  logic signed [SAMPLE_WIDTH-1:0]     i_sample,
  input  logic signed [SAMPLE_WIDTH-1:0]     q_sample,
  output logic                               busy,
  output logic                               valid_out,
  output logic signed [DATA_WIDTH-1:0]       i_out,
  output logic signed [DATA_WIDTH-1:0]       q_out,
  output logic                               start_count_out,
  output logic                               finish_count_out
);
  rx_state_e state, state_nx;
  logic [WINDOW_COUNTER_WIDTH-1:0] window_len_reg, len_sh, sample_cnt;
  logic [NUM_WINDOW_WIDTH-1:0] num_window_reg, nwin_sh, win_cnt;
  logic signed [ACC_WIDTH-1:0] acc_i, acc_q, sum_i, sum_q;
  logic signed [DATA_WIDTH-1:0] sat_i, sat_q;
  logic start_ok, take, win_end, last_win;

  assign start_ok = state == IDLE && meas_start;
  assign take = state == ACCUM && valid_in && !meas_abort;
  assign win_end = take && sample_cnt == len_sh - WINDOW_COUNTER_WIDTH'(1);
  assign last_win = win_end && win_cnt == nwin_sh - NUM_WINDOW_WIDTH'(1);
  // The window's closing sample goes straight into the output path so the accumulator can reload at once.
  assign sum_i = acc_i + ACC_WIDTH'(i_sample);
  assign sum_q = acc_q + ACC_WIDTH'(q_sample);

  readout_rx_iq_sat_shift #(.IN_WIDTH(ACC_WIDTH), .OUT_WIDTH(DATA_WIDTH), .SHIFT(OUT_SHIFT))
    u_sat_i (.din(sum_i), .dout(sat_i));
  readout_rx_iq_sat_shift #(.IN_WIDTH(ACC_WIDTH), .OUT_WIDTH(DATA_WIDTH), .SHIFT(OUT_SHIFT))
    u_sat_q (.din(sum_q), .dout(sat_q));

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;

  always_comb
    state_nx = state == IDLE ? (meas_start ? ACCUM : IDLE) : (meas_abort || last_win ? IDLE : ACCUM);

  always_comb busy = state == ACCUM;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      window_len_reg <= WINDOW_COUNTER_WIDTH'(1);
      num_window_reg <= NUM_WINDOW_WIDTH'(1);
    end else begin
      if (window_len_wr_en) window_len_reg <= window_len_wr_data;
      if (num_window_wr_en) num_window_reg <= num_window_wr_data;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc_i <= '0;
      acc_q <= '0;
      sample_cnt <= '0;
      win_cnt <= '0;
      len_sh <= WINDOW_COUNTER_WIDTH'(1);
      nwin_sh <= NUM_WINDOW_WIDTH'(1);
    end else if (start_ok) begin
      acc_i <= '0;
      acc_q <= '0;
      sample_cnt <= '0;
      win_cnt <= '0;
      len_sh <= window_len_reg == '0 ? WINDOW_COUNTER_WIDTH'(1) : window_len_reg;
      nwin_sh <= num_window_reg == '0 ? NUM_WINDOW_WIDTH'(1) : num_window_reg;
    end else if (state == ACCUM && meas_abort) begin
      acc_i <= '0;
      acc_q <= '0;
      sample_cnt <= '0;
      win_cnt <= '0;
    end else if (take) begin
      acc_i <= win_end ? '0 : sum_i;
      acc_q <= win_end ? '0 : sum_q;
      sample_cnt <= win_end ? '0 : sample_cnt + WINDOW_COUNTER_WIDTH'(1);
      win_cnt <= win_end ? win_cnt + NUM_WINDOW_WIDTH'(1) : win_cnt;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid_out <= 1'b0;
      i_out <= '0;
      q_out <= '0;
      start_count_out <= 1'b0;
      finish_count_out <= 1'b0;
    end else begin
      valid_out <= win_end;
      start_count_out <= win_end && win_cnt == '0;
      finish_count_out <= last_win;
      if (win_end) begin
        i_out <= sat_i;
        q_out <= sat_q;
      end
    end
endmodule

// File: tb/tb_readout_rx_iq_window_integrator.sv
// tb_readout_rx_iq_window_integrator: randomized scenarios checked against window sums computed per measurement.
module tb_readout_rx_iq_window_integrator;
  typedef struct packed { int cyc; int ia; int qa; int ib; int qb; logic [4:0] fl; } pt_t;

  logic clk = 0, rst = 0;
  logic window_len_wr_en = 0, num_window_wr_en = 0, meas_start = 0, meas_abort = 0, valid_in = 0;
  logic [7:0] window_len_wr_data = 0, num_window_wr_data = 0;
  logic signed [15:0] i_sample = 0, q_sample = 0;
  logic a_busy, a_valid, a_st, a_fin, b_busy, b_valid, b_st, b_fin;
  logic signed [15:0] a_i, a_q, b_i, b_q;
  int cyc = 0, errors = 0, checks = 0, mid_len = 0;
  bit mid_start = 0, busy_mid, busy_after;
  int si[$], sq[$];
  pt_t exp_q[$], obs_q[$];

  always #5 clk = ~clk;

  readout_rx_iq_window_integrator #(.OUT_SHIFT(0)) dut_a (
    .clk(clk), .rst(rst),
    .window_len_wr_en(window_len_wr_en), .window_len_wr_data(window_len_wr_data),
    .num_window_wr_en(num_window_wr_en), .num_window_wr_data(num_window_wr_data),
    .meas_start(meas_start), .meas_abort(meas_abort), .valid_in(valid_in),
    .i_sample(i_sample), .q_sample(q_sample), .busy(a_busy), .valid_out(a_valid),
    .i_out(a_i), .q_out(a_q), .start_count_out(a_st), .finish_count_out(a_fin));

  readout_rx_iq_window_integrator #(.OUT_SHIFT(2)) dut_b (
    .clk(clk), .rst(rst),
    .window_len_wr_en(window_len_wr_en), .window_len_wr_data(window_len_wr_data),
    .num_window_wr_en(num_window_wr_en), .num_window_wr_data(num_window_wr_data),
    .meas_start(meas_start), .meas_abort(meas_abort), .valid_in(valid_in),
    .i_sample(i_sample), .q_sample(q_sample), .busy(b_busy), .valid_out(b_valid),
    .i_out(b_i), .q_out(b_q), .start_count_out(b_st), .finish_count_out(b_fin));

  function automatic int ref_pt(input longint sum, input int sh);
    longint v = sum >>> sh;
    return int'(v > 32767 ? 32767 : (v < -32768 ? -32768 : v));
  endfunction

  task automatic tick();
    @(posedge clk); #1; cyc++;
    if (a_valid) obs_q.push_back('{cyc, int'(a_i), int'(a_q), int'(b_i), int'(b_q), {a_st, a_fin, b_valid, b_st, b_fin}});
  endtask

  task automatic cfg(input int len, input int nw);
    window_len_wr_en = 1; window_len_wr_data = 8'(len);
    num_window_wr_en = 1; num_window_wr_data = 8'(nw);
    tick();
    window_len_wr_en = 0; num_window_wr_en = 0;
  endtask

  task automatic fill(input int n, input int vi, input int vq, input bit rnd);
    si.delete(); sq.delete();
    for (int k = 0; k < n; k++) begin
      si.push_back(rnd ? int'($urandom_range(65535)) - 32768 : vi);
      sq.push_back(rnd ? int'($urandom_range(65535)) - 32768 : vq);
    end
  endtask

  // One measurement: expected points are the plain sums of each consecutive group of len accepted samples.
  task automatic run(input int len, input int nwin, input int gaps, input int abort_at, input bit abort_v);
    longint wi = 0, wq = 0;
    int n = 0, w = 0;
    meas_start = 1; tick(); meas_start = 0; busy_mid = a_busy;
    foreach (si[k]) begin
      if (gaps == 1) tick();
      else if (gaps == 2) repeat ($urandom_range(2)) tick();
      valid_in = 1; i_sample = 16'(si[k]); q_sample = 16'(sq[k]);
      if (k == 1 && mid_len > 0) begin window_len_wr_en = 1; window_len_wr_data = 8'(mid_len); end
      meas_start = mid_start && k == 2;
      if (k == abort_at) begin
        meas_abort = 1; valid_in = abort_v;
      end else begin
        wi += si[k]; wq += sq[k]; n++;
        if (n == len) begin
          exp_q.push_back('{cyc + 1, ref_pt(wi, 0), ref_pt(wq, 0), ref_pt(wi, 2), ref_pt(wq, 2),
                            {w == 0, w == nwin - 1, 1'b1, w == 0, w == nwin - 1}});
          n = 0; wi = 0; wq = 0; w++;
        end
      end
      tick();
      valid_in = 0; meas_abort = 0; meas_start = 0; window_len_wr_en = 0;
      if (k == abort_at) break;
    end
    busy_after = a_busy;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) tick();
    checks++;
    if ({a_valid, a_st, a_fin, a_busy, a_i, a_q} !== '0) begin
      errors++; $display("FAIL reset_a got %h want 0", {a_valid, a_st, a_fin, a_busy, a_i, a_q});
    end
    checks++;
    if ({b_valid, b_st, b_fin, b_busy, b_i, b_q} !== '0) begin
      errors++; $display("FAIL reset_b got %h want 0", {b_valid, b_st, b_fin, b_busy, b_i, b_q});
    end
    rst = 1;
    tick();
  endtask

  task automatic test_basic();
    pt_t o;
    obs_q.delete(); exp_q.delete();
    cfg(4, 1); fill(4, 0, -1, 0); si = '{1, 2, 3, 4};
    run(4, 1, 0, -1, 0);
    checks++;
    if (busy_mid !== 1'b1) begin errors++; $display("FAIL basic busy_mid got %b want 1", busy_mid); end
    checks++;
    if (busy_after !== 1'b0) begin errors++; $display("FAIL basic busy_after got %b want 0", busy_after); end
    cfg(5, 2); fill(10, 0, 0, 1);
    run(5, 2, 2, -1, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      o = k < obs_q.size() ? obs_q[k] : pt_t'(0);
      checks++;
      if (o !== exp_q[k]) begin errors++; $display("FAIL basic pt%0d got %p want %p", k, o, exp_q[k]); end
    end
  endtask

  task automatic test_gaps();
    pt_t o;
    obs_q.delete(); exp_q.delete();
    cfg(2, 3); fill(6, 100, 0, 0);
    run(2, 3, 1, -1, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL gaps count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      o = k < obs_q.size() ? obs_q[k] : pt_t'(0);
      checks++;
      if (o !== exp_q[k]) begin errors++; $display("FAIL gaps pt%0d got %p want %p", k, o, exp_q[k]); end
    end
  endtask

  task automatic test_saturation();
    pt_t o;
    obs_q.delete(); exp_q.delete();
    cfg(4, 1);
    fill(4, 32767, 32767, 0); run(4, 1, 0, -1, 0);
    fill(4, -32768, -32768, 0); run(4, 1, 0, -1, 0);
    cfg(8, 2); fill(16, 0, 0, 1); run(8, 2, 0, -1, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL sat count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      o = k < obs_q.size() ? obs_q[k] : pt_t'(0);
      checks++;
      if (o !== exp_q[k]) begin errors++; $display("FAIL sat pt%0d got %p want %p", k, o, exp_q[k]); end
    end
  endtask

  task automatic test_shift();
    pt_t o;
    obs_q.delete(); exp_q.delete();
    cfg(1, 1); fill(1, -5, 5, 0); run(1, 1, 0, -1, 0);
    cfg(0, 0); fill(1, 0, 0, 1); run(1, 1, 0, -1, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL shift count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      o = k < obs_q.size() ? obs_q[k] : pt_t'(0);
      checks++;
      if (o !== exp_q[k]) begin errors++; $display("FAIL shift pt%0d got %p want %p", k, o, exp_q[k]); end
    end
  endtask

  task automatic test_abort();
    pt_t o;
    obs_q.delete(); exp_q.delete();
    cfg(4, 1);
    fill(4, 0, 0, 1); run(4, 1, 0, 3, 0);
    checks++;
    if (busy_after !== 1'b0) begin errors++; $display("FAIL abort busy_after got %b want 0", busy_after); end
    fill(4, 0, 0, 1); run(4, 1, 0, 3, 1);
    fill(4, 0, 0, 1); run(4, 1, 2, -1, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL abort count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      o = k < obs_q.size() ? obs_q[k] : pt_t'(0);
      checks++;
      if (o !== exp_q[k]) begin errors++; $display("FAIL abort pt%0d got %p want %p", k, o, exp_q[k]); end
    end
  endtask

  task automatic test_shadow();
    pt_t o;
    obs_q.delete(); exp_q.delete();
    cfg(4, 1); fill(4, 0, 0, 1);
    mid_len = 8; mid_start = 1;
    run(4, 1, 0, -1, 0);
    mid_len = 0; mid_start = 0;
    fill(8, 0, 0, 1); run(8, 1, 2, -1, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL shadow count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      o = k < obs_q.size() ? obs_q[k] : pt_t'(0);
      checks++;
      if (o !== exp_q[k]) begin errors++; $display("FAIL shadow pt%0d got %p want %p", k, o, exp_q[k]); end
    end
  endtask

  task automatic test_back_to_back();
    pt_t o;
    int len, nw;
    obs_q.delete(); exp_q.delete();
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(6, 1); nw = $urandom_range(4, 1);
      cfg(len, nw);
      fill(len * nw, 0, 0, 1); run(len, nw, 2, -1, 0);
      fill(len * nw, 0, 0, 1); run(len, nw, 0, -1, 0);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      o = k < obs_q.size() ? obs_q[k] : pt_t'(0);
      checks++;
      if (o !== exp_q[k]) begin errors++; $display("FAIL b2b pt%0d got %p want %p", k, o, exp_q[k]); end
    end
  endtask

  task automatic test_async_reset();
    pt_t o;
    cfg(3, 2);
    meas_start = 1; tick(); meas_start = 0;
    repeat (3) begin
      valid_in = 1; i_sample = 16'sd1000; q_sample = -16'sd1000;
      tick();
    end
    valid_in = 0;
    checks++;
    if ({a_valid, a_i} !== {1'b1, 16'sd3000}) begin errors++; $display("FAIL prereset got %h want %h", {a_valid, a_i}, {1'b1, 16'sd3000}); end
    #2 rst = 0;
    #1;
    checks++;
    if ({a_valid, a_st, a_busy, a_i, a_q, b_i} !== '0) begin
      errors++; $display("FAIL async_reset got %h want 0", {a_valid, a_st, a_busy, a_i, a_q, b_i});
    end
    tick();
    rst = 1;
    obs_q.delete(); exp_q.delete();
    fill(1, 0, 0, 1); run(1, 1, 0, -1, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL cfg_reset count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      o = k < obs_q.size() ? obs_q[k] : pt_t'(0);
      checks++;
      if (o !== exp_q[k]) begin errors++; $display("FAIL cfg_reset pt%0d got %p want %p", k, o, exp_q[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_saturation();
    test_shift();
    test_abort();
    test_shadow();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
